// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Multi-cycle RV32I data-memory controller with a valid/ready
//            request port, fixed access latency and byte/half/word accesses.
//            Optional misalignment rejection: define DMEM_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned NUM_LANES = DATA_W / 8;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_is_half;
    logic                w_is_word;
    logic                w_f3_ok;
    logic                w_misalign;
    logic [1:0]          w_off;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_commit;
    logic                err_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [NUM_LANES-1:0] wmask_d;
    logic [DATA_W-1:0]   wdata_d;

    assign w_idx     = IDX_W'(32'(addr_q[ADDR_W-1:2]) % DEPTH);
    assign w_rd_word = mem_q[w_idx];
    assign w_is_half = (funct3_q[1:0] == 2'b01);
    assign w_is_word = (funct3_q[1:0] == 2'b10);
    assign w_f3_ok   = write_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                               : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = (w_is_half && addr_q[0]) || (w_is_word && (addr_q[1:0] != 2'b00));
    assign w_off      = addr_q[1:0];
`else
    // Misaligned halves/words are silently aligned down instead of rejected.
    assign w_misalign = 1'b0;
    assign w_off      = w_is_word ? 2'b00 : (w_is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif

    assign err_d  = !w_f3_ok || w_misalign;
    assign w_byte = w_rd_word[{w_off, 3'b000} +: 8];
    assign w_half = w_rd_word[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        rdata_d = '0;
        if (!write_q && !err_d) begin
            case (funct3_q)
                3'b000:  rdata_d = {{24{w_byte[7]}}, w_byte};
                3'b001:  rdata_d = {{16{w_half[15]}}, w_half};
                3'b010:  rdata_d = w_rd_word;
                3'b100:  rdata_d = {24'd0, w_byte};
                3'b101:  rdata_d = {16'd0, w_half};
                default: rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        wmask_d = '0;
        wdata_d = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                wmask_d = NUM_LANES'(4'b0001 << w_off);
                wdata_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask_d = w_off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_q[15:0]}};
            end
            2'b10:   wmask_d = 4'b1111;
            default: wmask_d = '0;
        endcase
    end

    // Store commits on the same edge that moves WAIT->RESP, so a reset
    // arriving earlier in WAIT discards it.
    assign w_commit = (state_q == WAIT) && (cnt_q == '0) && write_q && !err_d;

    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (wmask_d[b]) begin
                    mem_q[w_idx][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= CNT_W'(LATENCY - 1);
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == WAIT) || (state_q == RESP);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Directed, scoreboard-based self-checking bench for dmem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned LATENCY = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int total  = 0;
    int passed = 0;
    logic [32:0] exp_q[$];

    dmem_ctrl #(
        .DEPTH   (128),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY),
        .DATA_W  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic pop_cmp(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
            chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
        int k;
        int low;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        exp_q.push_back({ee, er});
        k   = 0;
        low = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            k++;
            if (!req_ready) low++;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end while (!rsp_valid && k < 20);
        chk({tag, "_latency"}, k - 1, LATENCY);
        if (rsp_valid) pop_cmp(tag);
        @(negedge clk);
        chk({tag, "_ready_low_cycles"}, low, LATENCY + 1);
        chk({tag, "_pulse_end"}, {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int accepts;
        int rsps;
        int last;
        int stray;

        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_req("sw30",   1, 3'b010, 9'h030, 32'hDEADBEEF, 32'h0, 0);
        do_req("lw30",   0, 3'b010, 9'h030, 32'h0, 32'hDEADBEEF, 0);
        do_req("sb31",   1, 3'b000, 9'h031, 32'hAAAAAA80, 32'h0, 0);
        do_req("lb31",   0, 3'b000, 9'h031, 32'h0, 32'hFFFFFF80, 0);
        do_req("lbu31",  0, 3'b100, 9'h031, 32'h0, 32'h00000080, 0);
        do_req("lw30b",  0, 3'b010, 9'h030, 32'h0, 32'hDEAD80EF, 0);
        do_req("sh32",   1, 3'b001, 9'h032, 32'h55558001, 32'h0, 0);
        do_req("lh32",   0, 3'b001, 9'h032, 32'h0, 32'hFFFF8001, 0);
        do_req("lhu32",  0, 3'b101, 9'h032, 32'h0, 32'h00008001, 0);
        do_req("lw30c",  0, 3'b010, 9'h030, 32'h0, 32'h800180EF, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        do_req("lw31_mis", 0, 3'b010, 9'h031, 32'h0, 32'h0, 1);
        do_req("sh33_mis", 1, 3'b001, 9'h033, 32'h0000FFFF, 32'h0, 1);
`else
        do_req("lw31_mis", 0, 3'b010, 9'h031, 32'h0, 32'h800180EF, 0);
        do_req("lhu33_mis", 0, 3'b101, 9'h033, 32'h0, 32'h00008001, 0);
`endif
        do_req("ld_f3_011", 0, 3'b011, 9'h030, 32'h0, 32'h0, 1);
        do_req("st_f3_011", 1, 3'b011, 9'h030, 32'hFFFFFFFF, 32'h0, 1);
        do_req("lw30d",  0, 3'b010, 9'h030, 32'h0, 32'h800180EF, 0);
        do_req("sw1fc",  1, 3'b010, 9'h1FC, 32'hCAFEF00D, 32'h0, 0);
        do_req("lhu1fe", 0, 3'b101, 9'h1FE, 32'h0, 32'h0000CAFE, 0);
        do_req("lb1fd",  0, 3'b000, 9'h1FD, 32'h0, 32'hFFFFFFF0, 0);

        // Reset in the middle of an in-flight store.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 9'h040;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        chk("midrst_err", {31'd0, rsp_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        chk("midrst_no_rsp", stray, 0);
        do_req("lw40",   0, 3'b010, 9'h040, 32'h0, 32'h0, 0);

        // Hold req_valid high continuously.
        accepts    = 0;
        rsps       = 0;
        last       = -1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 9'h030;
        for (int c = 0; c < 4 * (LATENCY + 2); c++) begin
            chk("hold_busy_vs_ready", {31'd0, busy}, {31'd0, !req_ready});
            if (req_ready) begin
                accepts++;
                exp_q.push_back({1'b0, 32'h800180EF});
                if (last >= 0) chk("hold_accept_gap", c - last, LATENCY + 2);
                last = c;
            end
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                rsps++;
                pop_cmp("hold");
            end
        end
        req_valid = 1'b0;
        chk("hold_accepts", accepts, 4);
        chk("hold_rsps", rsps, 4);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, multi-cycle data-memory controller for the RISC-V datapath. It replaces the combinational word-only data memory with a valid/ready request port, a configurable access latency, and full RV32I load/store widths (byte, half, word, signed and unsigned). It sits between the ALU address output and the register-file write-back mux. The core stalls on req_ready and on the absence of rsp_valid.

Parameters:
- DEPTH, 128, number of DATA_W-bit words stored.
- ADDR_W, 9, byte-address width; word index = req_addr[ADDR_W-1:2] mod DEPTH.
- LATENCY, 2, cycles from request accept to response (legal range >= 1).
- DATA_W, 32, word width. Fixed at 32 for RV32; 4 byte lanes.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; equals (state==IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 giving access size and sign.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; low bits used for sb/sh.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_W  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  access rejected; qualified by rsp_valid.
- busy  output  1  high in WAIT and RESP states.

Behaviour:
- Reset is asynchronous, active-high, clock clk.
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Memory array is not cleared by reset; it is zero-initialised at time 0 only.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: capture write, funct3, addr, wdata; load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0; incoming requests are ignored, not queued.
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access on this edge (store commits to the array, load registers rsp_rdata) and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; then go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next response.
- Timing: a request accepted at edge N gives rsp_valid high after edge N+LATENCY. The earliest next accept is edge N+LATENCY+2.
- Load funct3:
  - 000 lb: sign-extend the selected byte.
  - 001 lh: sign-extend the selected half.
  - 010 lw: full word.
  - 100 lbu: zero-extend the selected byte.
  - 101 lhu: zero-extend the selected half.
- Store funct3:
  - 000 sb: write only lane addr[1:0].
  - 001 sh: write only lanes {addr[1],0} and {addr[1],1}.
  - 010 sw: write all four lanes.
- Lane selection: byte = addr[1:0]; half = addr[1]. Little-endian.
- Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010):
  - No memory change, rsp_rdata=0, rsp_err=1.
  - This applies regardless of the macro.
- Address wrap: the word index wraps modulo DEPTH. It is never an error.
- Reset asserted mid-WAIT: the in-flight store is discarded (never committed) and no response is issued.
- A load following a store to the same word returns the new data, because the store commits before its RESP.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned access is rejected: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
  - Rejection means no write, rsp_rdata=0, rsp_err=1, with normal latency.
- Undefined:
  - The offending low address bits are forced to 0 (access is aligned down).
  - rsp_err is raised only for illegal funct3.

Test Plan:
- sw 0xDEADBEEF @0x30, then lw @0x30 with LATENCY=2 -> rsp_valid exactly 2 edges after each accept; rdata=0xDEADBEEF; err=0; req_ready low for 3 cycles per access.
- sb 0x80 @0x31, then lb @0x31 / lbu @0x31 / lw @0x30 -> 0xFFFFFF80 / 0x00000080 / 0xDEAD80EF.
- sh 0x8001 @0x32, then lh @0x32 / lhu @0x32 -> 0xFFFF8001 / 0x00008001; lw @0x30 -> 0x800180EF.
- lw @0x31 -> with DMEM_MISALIGN_CHECK_EN: rdata=0, err=1; without: rdata=word@0x30, err=0. Load funct3=011 -> err=1 in both builds.
- Assert reset one cycle after accepting sw 0x12345678 @0x40 -> no rsp_valid; outputs reset to 0; later lw @0x40 returns the prior value (0).
- Hold req_valid high continuously through WAIT/RESP -> only one accept per LATENCY+2 cycles; busy matches the WAIT/RESP states.
